// File: rtl/alarm_buzzer_seq.sv
// alarm_buzzer_seq
//
// Takes the 7-bit PIO word written by the alarm firmware, decodes it into an
// enable, a beep pattern and a tone pitch, and generates the gated
// square-wave buzzer drive for the alarm board. All audible timing lives here,
// so firmware only writes the word once per alarm-state change.
//
// Ports:
//   clk           system clock (single domain)
//   reset_n       synchronous active-low reset
//   pio_word[6]   enable
//   pio_word[5:4] pattern: 00 continuous, 01 slow, 10 fast, 11 triple
//   pio_word[3:0] tone select, half-period = TONE_UNIT*(tone+1) clocks
//   buzzer        registered buzzer drive
//   alarm_active  registered, high whenever the sequencer is not idle
//   beat          registered beat index within the triple pattern (0..2)
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | alarm disabled, buzzer silent
//   S_ON    | buzzer follows the tone square wave
//   S_OFF   | silent gap between beeps
//   S_PAUSE | silent gap after the third beep of the triple pattern

module alarm_buzzer_seq #(
    parameter int TICK_DIV  = 50000,
    parameter int TONE_UNIT = 2500,
    parameter int SLOW_MS   = 500,
    parameter int FAST_MS   = 125,
    parameter int TRIPLE_MS = 100,
    parameter int PAUSE_MS  = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] pio_word,
    output logic       buzzer,
    output logic       alarm_active,
    output logic [1:0] beat
);

    // Counter widths are derived from the parameters so that the longest
    // half-period (tone 15) and the longest phase always fit.
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int TONE_W = $clog2(TONE_UNIT * 16 + 1);
    localparam int MAX_A  = (SLOW_MS > FAST_MS) ? SLOW_MS : FAST_MS;
    localparam int MAX_B  = (TRIPLE_MS > PAUSE_MS) ? TRIPLE_MS : PAUSE_MS;
    localparam int MAX_MS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MS_W   = $clog2(MAX_MS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    logic [6:0]        cfg_q;
    logic [6:0]        cfg_d;
    logic [1:0]        pattern;
    logic [3:0]        tone_sel;

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_n;
    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] tone_cnt_n;
    logic [TONE_W-1:0] tone_term;
    logic [MS_W-1:0]   ms_cnt;
    logic [MS_W-1:0]   ms_cnt_n;
    logic [MS_W-1:0]   dur_term;

    logic              tone_q;
    logic              tone_q_n;
    logic              tick;
    logic              phase_done;
    logic              enter;
    logic [1:0]        beat_n;
    logic              buzzer_n;
    logic              active_n;

    assign pattern  = cfg_q[5:4];
    assign tone_sel = cfg_q[3:0];

    // Terminal counts for the current tone and phase.
    assign tone_term = TONE_W'(TONE_UNIT * (int'(tone_sel) + 1) - 1);
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_comb begin
        dur_term = '0;
        if (state == S_PAUSE) begin
            dur_term = MS_W'(PAUSE_MS - 1);
        end else begin
            unique case (pattern)
                2'b01:   dur_term = MS_W'(SLOW_MS - 1);
                2'b10:   dur_term = MS_W'(FAST_MS - 1);
                2'b11:   dur_term = MS_W'(TRIPLE_MS - 1);
                default: dur_term = '0;
            endcase
        end
    end

    assign phase_done = tick && (ms_cnt == dur_term);

    // Next-state logic. "enter" marks any edge that starts a fresh ON, OFF or
    // PAUSE phase, including a restart of ON caused by a config change.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        enter   = 1'b0;
        if (!cfg_q[6]) begin
            state_n = S_IDLE;
            beat_n  = 2'd0;
        end else if ((state == S_IDLE) || (cfg_q != cfg_d)) begin
            state_n = S_ON;
            beat_n  = 2'd0;
            enter   = 1'b1;
        end else begin
            unique case (state)
                S_ON: begin
                    if ((pattern != 2'b00) && phase_done) begin
                        state_n = S_OFF;
                        enter   = 1'b1;
                    end
                end
                S_OFF: begin
                    if (phase_done) begin
                        enter = 1'b1;
                        if (pattern != 2'b11) begin
                            state_n = S_ON;
                        end else if (beat < 2'd2) begin
                            state_n = S_ON;
                            beat_n  = beat + 2'd1;
                        end else begin
                            state_n = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (phase_done) begin
                        state_n = S_ON;
                        beat_n  = 2'd0;
                        enter   = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    beat_n  = 2'd0;
                end
            endcase
        end
    end

    // Counter and tone next values.
    always_comb begin
        tick_cnt_n = tick_cnt;
        tone_cnt_n = tone_cnt;
        ms_cnt_n   = ms_cnt;
        tone_q_n   = tone_q;
        if (state_n == S_IDLE) begin
            tick_cnt_n = '0;
            tone_cnt_n = '0;
            ms_cnt_n   = '0;
            tone_q_n   = 1'b0;
        end else if (enter) begin
            tick_cnt_n = '0;
            tone_cnt_n = '0;
            ms_cnt_n   = '0;
            // Every ON phase starts on the high half of the tone.
            if (state_n == S_ON) begin
                tone_q_n = 1'b1;
            end
        end else begin
            tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
            // Continuous mode never ends its phase, so ms_cnt is left at 0
            // there instead of being allowed to wrap.
            if (tick && (pattern != 2'b00)) begin
                ms_cnt_n = ms_cnt + 1'b1;
            end
            if (state == S_ON) begin
                if (tone_cnt == tone_term) begin
                    tone_cnt_n = '0;
                    tone_q_n   = ~tone_q;
                end else begin
                    tone_cnt_n = tone_cnt + 1'b1;
                end
            end
        end
    end

    // The buzzer flop loads the next-state gated tone, so the pin never sees
    // a combinational glitch between state and tone.
    assign buzzer_n = (state_n == S_ON) && tone_q_n;
    assign active_n = (state_n != S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cfg_q        <= '0;
            cfg_d        <= '0;
            tick_cnt     <= '0;
            tone_cnt     <= '0;
            ms_cnt       <= '0;
            tone_q       <= 1'b0;
            beat         <= 2'd0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            state        <= state_n;
            cfg_q        <= pio_word;
            cfg_d        <= cfg_q;
            tick_cnt     <= tick_cnt_n;
            tone_cnt     <= tone_cnt_n;
            ms_cnt       <= ms_cnt_n;
            tone_q       <= tone_q_n;
            beat         <= beat_n;
            buzzer       <= buzzer_n;
            alarm_active <= active_n;
        end
    end

endmodule

// File: tb/tb_alarm_buzzer_seq.sv
module tb_alarm_buzzer_seq;

    localparam int TICK_DIV  = 4;
    localparam int TONE_UNIT = 2;
    localparam int SLOW_MS   = 3;
    localparam int FAST_MS   = 2;
    localparam int TRIPLE_MS = 1;
    localparam int PAUSE_MS  = 2;

    logic       clk;
    logic       reset_n;
    logic [6:0] pio_word;
    logic       buzzer;
    logic       alarm_active;
    logic [1:0] beat;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    alarm_buzzer_seq #(
        .TICK_DIV (TICK_DIV),
        .TONE_UNIT(TONE_UNIT),
        .SLOW_MS  (SLOW_MS),
        .FAST_MS  (FAST_MS),
        .TRIPLE_MS(TRIPLE_MS),
        .PAUSE_MS (PAUSE_MS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pio_word    (pio_word),
        .buzzer      (buzzer),
        .alarm_active(alarm_active),
        .beat        (beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase (0 idle, 1 on, 2 off, 3 pause), age in clocks
    // since the phase began, and the beat index. The buzzer level follows
    // from the age and the half-period by plain division.
    int         m_phase = 0;
    int         m_age   = 0;
    int         m_beat  = 0;
    int         m_tone  = 0;
    logic [6:0] m_q     = '0;
    logic [6:0] m_d     = '0;

    function automatic int phase_ms(input int pat, input int ph);
        if (ph == 3) return PAUSE_MS;
        case (pat)
            1:       return SLOW_MS;
            2:       return FAST_MS;
            3:       return TRIPLE_MS;
            default: return 1;
        endcase
    endfunction

    task automatic model_step(input logic rst_n_i, input logic [6:0] w);
        int pat;
        int len;
        if (!rst_n_i) begin
            m_phase = 0; m_age = 0; m_beat = 0; m_tone = 0;
            m_q = '0; m_d = '0;
        end else begin
            pat    = int'(m_q[5:4]);
            m_tone = int'(m_q[3:0]);
            if (!m_q[6]) begin
                m_phase = 0; m_age = 0; m_beat = 0;
            end else if (m_phase == 0 || m_q != m_d) begin
                m_phase = 1; m_age = 0; m_beat = 0;
            end else begin
                len = phase_ms(pat, m_phase) * TICK_DIV;
                if ((m_phase == 1 && pat == 0) || m_age < len - 1) begin
                    m_age++;
                end else begin
                    m_age = 0;
                    if (m_phase == 1) begin
                        m_phase = 2;
                    end else if (m_phase == 2) begin
                        if (pat != 3) m_phase = 1;
                        else if (m_beat < 2) begin m_phase = 1; m_beat++; end
                        else m_phase = 3;
                    end else begin
                        m_phase = 1; m_beat = 0;
                    end
                end
            end
            m_d = m_q;
            m_q = w;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: the model consumes the inputs that the DUT sampled.
    task automatic step();
        @(posedge clk);
        model_step(reset_n, pio_word);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin : compare
        int hp;
        int eb;
        if (chk_en) begin
            hp = TONE_UNIT * (m_tone + 1);
            eb = (m_phase == 1 && ((m_age / hp) % 2) == 0) ? 1 : 0;
            check("cyc_buzzer", int'(buzzer), eb);
            check("cyc_active", int'(alarm_active), (m_phase != 0) ? 1 : 0);
            check("cyc_beat", int'(beat), m_beat);
        end
    end

    task automatic wait_phase(input int ph, input int budget);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            step();
            n++;
        end
        check("wait_phase_reached", (m_phase == ph) ? 1 : 0, 1);
    endtask

    task automatic check_out(input string name, input int bz, input int act, input int bt);
        check({name, "_buzzer"}, int'(buzzer), bz);
        check({name, "_active"}, int'(alarm_active), act);
        check({name, "_beat"}, int'(beat), bt);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [1:0] r_pat;
        logic [3:0] r_tone;
        reset_n  = 1'b0;
        pio_word = 7'h7F;

        // 1: reset with everything enabled, then continuous mode
        for (int i = 0; i < 3; i++) begin
            step();
            chk_en = 1'b1;
            check_out("reset", 0, 0, 0);
        end
        reset_n  = 1'b1;
        pio_word = 7'h40;
        step();
        check_out("en_edgeN", 0, 0, 0);
        step();
        check_out("en_edgeN1", 1, 1, 0);
        step();
        check("cont_age1", int'(buzzer), 1);
        step();
        check("cont_age2", int'(buzzer), 0);
        steps(20);
        check("cont_no_off", int'(alarm_active), 1);

        // 2: slow pattern, tone 1
        pio_word = 7'h51;
        steps(2);
        check_out("slow_start", 1, 1, 0);
        steps(4);
        check("slow_half", int'(buzzer), 0);
        steps(8);
        check_out("slow_off", 0, 1, 0);
        steps(12);
        check_out("slow_on2", 1, 1, 0);
        steps(24);

        // 3: triple pattern
        pio_word = 7'h70;
        steps(2);
        check_out("tri_b0", 1, 1, 0);
        steps(8);
        check_out("tri_b1", 1, 1, 1);
        steps(8);
        check_out("tri_b2", 1, 1, 2);
        steps(8);
        check_out("tri_pause", 0, 1, 2);
        steps(8);
        check_out("tri_wrap", 1, 1, 0);

        // 4: tone change mid ON restarts the phase
        pio_word = 7'h51;
        steps(2);
        steps(5);
        pio_word = 7'h52;
        step();
        step();
        check_out("restart", 1, 1, 0);
        steps(5);
        check("restart_age5", int'(buzzer), 1);
        step();
        check("restart_age6", int'(buzzer), 0);
        steps(6);
        check_out("restart_off", 0, 1, 0);

        // 5: disable during beat 1, then a repeated write starts once
        pio_word = 7'h70;
        steps(2);
        steps(8);
        check("dis_beat1", int'(beat), 1);
        step();
        pio_word = 7'h00;
        step();
        check("dis_edgeN", int'(alarm_active), 1);
        step();
        check_out("dis_edgeN1", 0, 0, 0);
        pio_word = 7'h51;
        step();
        step();
        check_out("rewrite_start", 1, 1, 0);
        steps(4);
        check("rewrite_no_restart", int'(buzzer), 0);

        // 6: reset in the middle of PAUSE
        pio_word = 7'h70;
        wait_phase(3, 200);
        steps(2);
        reset_n = 1'b0;
        step();
        check_out("rst_pause", 0, 0, 0);
        reset_n = 1'b1;
        step();
        check("rst_release", int'(alarm_active), 0);
        step();
        check_out("rst_restart", 1, 1, 0);

        // Randomised traffic, checked every cycle against the model
        for (int it = 0; it < 80; it++) begin
            r_pat  = 2'($urandom_range(0, 3));
            r_tone = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                pio_word = {1'b0, r_pat, r_tone};
            else
                pio_word = {1'b1, r_pat, r_tone};
            if ($urandom_range(0, 9) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
            steps(int'($urandom_range(1, 50)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/alarm_buzzer_seq.md
Name: alarm_buzzer_seq

Overview:
- Downstream consumer of the 7-bit PIO output word that the Nios alarm firmware writes.
- Decodes the word into enable, beep pattern and tone pitch.
- Generates a gated square-wave buzzer drive and an activity flag for the alarm board.
- Owns all audible-alarm timing in hardware, so firmware performs one PIO write per alarm-state change.

Parameters:
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz).
- TONE_UNIT, 2500, clk cycles per tone half-period unit; half-period = TONE_UNIT*(tone+1).
- SLOW_MS, 500, ON and OFF phase length for pattern 01, in ticks.
- FAST_MS, 125, ON and OFF phase length for pattern 10, in ticks.
- TRIPLE_MS, 100, ON and OFF phase length of each beep for pattern 11, in ticks.
- PAUSE_MS, 500, silence after the third beep of pattern 11, in ticks.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  synchronous active-low reset.
- pio_word  in  7  PIO out_port.
  - [6] enable.
  - [5:4] pattern: 00 continuous, 01 slow, 10 fast, 11 triple.
  - [3:0] tone select.
- buzzer  out  1  registered buzzer drive.
- alarm_active  out  1  registered; 1 whenever the FSM is not in IDLE.
- beat  out  2  registered beat index within the triple pattern (0..2); 0 for other patterns.

Behaviour:
Reset and input capture:
- Reset is synchronous on a clk edge with reset_n=0.
- Reset values: state=IDLE, buzzer=0, alarm_active=0, beat=0, all counters 0, cfg_q=0, cfg_d=0.
- pio_word is registered into cfg_q every edge. cfg_d holds the previous cfg_q value.
- The FSM acts only on cfg_q, which gives one cycle of input latency.

Tick and tone generation:
- tick_cnt counts 0..TICK_DIV-1 and asserts tick at TICK_DIV-1.
- tone_cnt counts 0..TONE_UNIT*(tone+1)-1 and toggles tone_q at the terminal count. Use a 24-bit-safe width derived from parameters.
- tick_cnt, tone_cnt and ms_cnt are cleared on every entry to ON, OFF or PAUSE.
- tone_q is set to 1 on every entry to ON.

FSM states and transitions:
- IDLE: buzzer=0.
  - cfg_q[6]=1 → ON with beat=0.
- ON: buzzer follows tone_q.
  - Pattern 00 stays in ON indefinitely.
  - Otherwise, on tick with ms_cnt=DUR-1 → OFF. DUR is SLOW_MS, FAST_MS or TRIPLE_MS, selected by pattern.
- OFF: buzzer=0.
  - On tick with ms_cnt=DUR-1, pattern 01/10 → ON.
  - Pattern 11 with beat<2 → ON with beat+1.
  - Pattern 11 with beat=2 → PAUSE.
- PAUSE: buzzer=0.
  - On tick with ms_cnt=PAUSE_MS-1 → ON with beat=0.

Priority, highest first:
1. reset_n=0.
2. cfg_q[6]=0 → IDLE. buzzer=0 and alarm_active=0 on the same edge.
3. cfg_q!=cfg_d while not IDLE (restart) → ON with beat=0 and counters cleared. This applies to pattern or tone changes, and a rewrite of the same value does not restart.
4. Normal progression.

Timing requirements:
- buzzer is a dedicated flop loaded with the next-state value. It must never be a combinational AND of state and tone.
- Enable latency: pio_word change before edge N is sampled into cfg_q at edge N; buzzer=1 and alarm_active=1 at edge N+1.
- Disable latency: the same two edges.

Boundary conditions:
- Tone select 15 gives the longest half-period, 16*TONE_UNIT.
- A tone change mid-ON restarts the phase. No partial half-period is emitted beyond the restart edge.
- Reset asserted in any state returns to IDLE on that edge, regardless of cfg.
- Parameter values of 1 must work. A DUR of 1 means each phase lasts exactly one tick period.

Test Plan:
Bench overrides TICK_DIV=4, TONE_UNIT=2, SLOW_MS=3, FAST_MS=2, TRIPLE_MS=1, PAUSE_MS=2.
1. Reset with pio_word=7'h7F held: reset_n=0 for 3 edges → buzzer=0, alarm_active=0, beat=0. Release, then pio_word=7'h40 → buzzer=1 two edges after the write, then toggles every 2 clk, continuous, no OFF phase.
2. pio_word=7'h51 (slow, tone 1) → buzzer toggles every 4 clk during ON. ON lasts 12 clk, OFF lasts 12 clk with buzzer=0, repeating. alarm_active stays 1 throughout.
3. pio_word=7'h70 (triple) → three ON/OFF pairs of 4 clk each with beat 0,1,2, then 8 clk PAUSE, then beat returns to 0 with buzzer=1.
4. In slow ON, change pio_word 7'h51→7'h52 mid-phase → restart: buzzer=1 on the second edge after the change. ON runs a full 12 clk from there, with a 6 clk half-period.
5. During triple beat 1, pio_word=7'h00 → buzzer=0, alarm_active=0, beat=0 two edges later. Rewriting 7'h51 twice in a row causes exactly one start, not a restart.
6. reset_n=0 for one edge mid-PAUSE with pio_word still enabled → IDLE on that edge. After release, ON with beat=0 on the next edge.
